fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the 16-bit pipeline. Owns the PC, drives the byte address into the

---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational instruction memory and
// fills the IF/ID register, handling stall, branch redirect, HALT freeze and sticky fetch faults.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 16'hF000,
    parameter int unsigned          MEM_BYTES = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                ir_valid,
    output logic [INSTR_W-1:0]  ir_instr,
    output logic [ADDR_W-1:0]   ir_pc,
    output logic                halted,
    output logic                fault,
    output logic [15:0]         fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(MEM_BYTES - 2);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(2);
    localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StFetch  = 2'd1,
        StHalted = 2'd2,
        StFault  = 2'd3
    } state_e;

    state_e             state;
    logic [ADDR_W-1:0]  pc;
    logic               br_bad;
    logic               pc_bad;
    logic               is_halt;

    assign imem_addr = pc;

    // A fetch address is legal only when word-aligned and inside the memory image.
    assign br_bad  = br_target[0] || (br_target > LAST_PC);
    assign pc_bad  = pc[0] || (pc > LAST_PC);
    assign is_halt = (imem_data == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StBoot;
            pc          <= RESET_PC;
            ir_valid    <= 1'b0;
            ir_instr    <= '0;
            ir_pc       <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            unique case (state)
                StBoot: begin
                    state <= StFetch;
                end

                StFetch: begin
                    if (br_valid) begin
                        ir_valid <= 1'b0;
                        if (br_bad) begin
                            state <= StFault;
                            fault <= 1'b1;
                        end else begin
                            pc <= br_target;
                        end
                    end else if (stall) begin
                        // hold everything, including a HALT word waiting at imem_data
                    end else if (pc_bad) begin
                        state    <= StFault;
                        fault    <= 1'b1;
                        ir_valid <= 1'b0;
                    end else begin
                        ir_instr <= imem_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        if (fetch_count != COUNT_MAX) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (is_halt) begin
                            state  <= StHalted;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end
                end

                StHalted: begin
                    if (br_valid) begin
                        // an older taken branch squashes the wrong-path HALT
                        halted   <= 1'b0;
                        ir_valid <= 1'b0;
                        if (br_bad) begin
                            state <= StFault;
                            fault <= 1'b1;
                        end else begin
                            state <= StFetch;
                            pc    <= br_target;
                        end
                    end else if (!stall) begin
                        ir_valid <= 1'b0;
                    end
                end

                StFault: begin
                    ir_valid <= 1'b0;
                    fault    <= 1'b1;
                end

                default: begin
                    state <= StFault;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte-array memory model, hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        br_valid;
    logic [15:0] br_target;
    logic        ir_valid;
    logic [15:0] ir_instr;
    logic [15:0] ir_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .ir_valid    (ir_valid),
        .ir_instr    (ir_instr),
        .ir_pc       (ir_pc),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    // Little-endian combinational read; outside the image reads as zero.
    always_comb begin
        imem_data = 16'h0000;
        if (imem_addr < 16'd63) begin
            imem_data = {mem[imem_addr[5:0] + 6'd1], mem[imem_addr[5:0]]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input int addr, input logic [15:0] val);
        mem[addr]     = val[7:0];
        mem[addr + 1] = val[15:8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic v, input logic [15:0] instr,
                            input logic [15:0] pc, input logic [15:0] cnt);
        check({tag, ".valid"}, 32'(ir_valid), 32'(v));
        if (v) begin
            check({tag, ".instr"}, 32'(ir_instr), 32'(instr));
            check({tag, ".pc"}, 32'(ir_pc), 32'(pc));
        end
        check({tag, ".count"}, 32'(fetch_count), 32'(cnt));
    endtask

    initial begin
        for (int a = 0; a < 64; a += 2) wr_word(a, 16'h1000 + 16'(a));
        wr_word(0, 16'h0E20);
        wr_word(2, 16'h0B21);
        wr_word(62, 16'hF000);

        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = 16'h0000;
        tick(); tick();
        check("rst.valid", 32'(ir_valid), 0);
        check("rst.instr", 32'(ir_instr), 0);
        check("rst.pc", 32'(ir_pc), 0);
        check("rst.halted", 32'(halted), 0);
        check("rst.fault", 32'(fault), 0);
        check("rst.count", 32'(fetch_count), 0);
        check("rst.addr", 32'(imem_addr), 0);

        // T1: boot cycle, then one word per edge
        rst = 1'b0;
        tick();
        check("boot.valid", 32'(ir_valid), 0);
        check("boot.addr", 32'(imem_addr), 0);
        tick(); check_ir("t1a", 1'b1, 16'h0E20, 16'h0000, 16'd1);
        check("t1a.addr", 32'(imem_addr), 32'h2);
        tick(); check_ir("t1b", 1'b1, 16'h0B21, 16'h0002, 16'd2);
        tick(); check_ir("t1c", 1'b1, 16'h1004, 16'h0004, 16'd3);

        // T2: stall three cycles at ir_pc 4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ir("t2.hold", 1'b1, 16'h1004, 16'h0004, 16'd3);
            check("t2.addr", 32'(imem_addr), 32'h6);
        end
        stall = 1'b0;
        tick(); check_ir("t2.resume", 1'b1, 16'h1006, 16'h0006, 16'd4);

        // T3: redirect beats stall, one bubble
        stall = 1'b1; br_valid = 1'b1; br_target = 16'h0014;
        tick();
        check("t3.bubble", 32'(ir_valid), 0);
        check("t3.addr", 32'(imem_addr), 32'h14);
        check("t3.count", 32'(fetch_count), 4);
        stall = 1'b0; br_valid = 1'b0;
        tick(); check_ir("t3.tgt", 1'b1, 16'h1014, 16'h0014, 16'd5);

        // T4: HALT at 0x3E
        br_valid = 1'b1; br_target = 16'h003C;
        tick(); check("t4.bubble", 32'(ir_valid), 0);
        br_valid = 1'b0;
        tick(); check_ir("t4.a", 1'b1, 16'h103C, 16'h003C, 16'd6);
        tick(); check_ir("t4.halt", 1'b1, 16'hF000, 16'h003E, 16'd7);
        check("t4.halted", 32'(halted), 1);
        check("t4.addr", 32'(imem_addr), 32'h3E);
        stall = 1'b1;
        tick(); check_ir("t4.stallhold", 1'b1, 16'hF000, 16'h003E, 16'd7);
        stall = 1'b0;
        tick(); check_ir("t4.drain", 1'b0, 16'h0, 16'h0, 16'd7);
        tick();
        check("t4.frozen.halted", 32'(halted), 1);
        check("t4.frozen.addr", 32'(imem_addr), 32'h3E);
        br_valid = 1'b1; br_target = 16'h0010;
        tick();
        check("t4.unhalt", 32'(halted), 0);
        check("t4.unhalt.addr", 32'(imem_addr), 32'h10);
        br_valid = 1'b0;
        tick(); check_ir("t4.refetch", 1'b1, 16'h1010, 16'h0010, 16'd8);

        // stall together with HALT: nothing latched until unstalled
        br_valid = 1'b1; br_target = 16'h003E;
        tick(); br_valid = 1'b0; stall = 1'b1;
        tick();
        check("sh.halted", 32'(halted), 0);
        check_ir("sh.hold", 1'b0, 16'h0, 16'h0, 16'd8);
        stall = 1'b0;
        tick();
        check("sh.halted2", 32'(halted), 1);
        check_ir("sh.load", 1'b1, 16'hF000, 16'h003E, 16'd9);

        // redirect together with HALT word: redirect wins
        br_valid = 1'b1; br_target = 16'h003E;
        tick(); check("bh.leave", 32'(halted), 0);
        br_target = 16'h0020;
        tick();
        check("bh.halted", 32'(halted), 0);
        check("bh.addr", 32'(imem_addr), 32'h20);
        check_ir("bh.bubble", 1'b0, 16'h0, 16'h0, 16'd9);
        br_valid = 1'b0;
        tick(); check_ir("bh.fetch", 1'b1, 16'h1020, 16'h0020, 16'd10);

        // T6: reset mid-run
        rst = 1'b1;
        tick();
        check_ir("t6.rst", 1'b0, 16'h0, 16'h0, 16'd0);
        check("t6.rst.instr", 32'(ir_instr), 0);
        check("t6.rst.irpc", 32'(ir_pc), 0);
        check("t6.rst.addr", 32'(imem_addr), 0);
        rst = 1'b0;
        tick(); check("t6.boot", 32'(ir_valid), 0);
        tick(); check_ir("t6.first", 1'b1, 16'h0E20, 16'h0000, 16'd1);

        // T5a: misaligned redirect, sticky until reset
        br_valid = 1'b1; br_target = 16'h0007;
        tick();
        check("t5a.fault", 32'(fault), 1);
        check("t5a.valid", 32'(ir_valid), 0);
        br_target = 16'h0010;
        tick();
        check("t5a.sticky", 32'(fault), 1);
        check("t5a.frozen", 32'(imem_addr), 32'h2);
        br_valid = 1'b0;

        // T5b: sequential PC walking off the end (HALT removed) and out-of-range target
        wr_word(62, 16'h103E);
        rst = 1'b1; tick();
        check("t5b.rst.fault", 32'(fault), 0);
        rst = 1'b0; tick();
        br_valid = 1'b1; br_target = 16'h003C;
        tick(); br_valid = 1'b0;
        tick(); check_ir("t5b.a", 1'b1, 16'h103C, 16'h003C, 16'd1);
        tick(); check_ir("t5b.b", 1'b1, 16'h103E, 16'h003E, 16'd2);
        check("t5b.b.fault", 32'(fault), 0);
        tick();
        check("t5b.fault", 32'(fault), 1);
        check_ir("t5b.nofetch", 1'b0, 16'h0, 16'h0, 16'd2);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        br_valid = 1'b1; br_target = 16'h0040;
        tick();
        check("t5c.range", 32'(fault), 1);
        br_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
